// File: rtl/tile_ram_to_fifo_pkg.sv
// Shared definitions for the tile RAM-to-FIFO loader: default widths,
// FSM state encoding, padding width and the legal RAM read latency range.
package tile_ram_to_fifo_pkg;

  localparam int AW_DEF     = 32;
  localparam int DW_DEF     = 32;
  localparam int DIM_W_DEF  = 16;
  localparam int RD_LAT_DEF = 2;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 8;
  localparam int PAD_W      = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // True when a read latency lies inside the supported range.
  function automatic bit lat_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/tile_ram_to_fifo_if.sv
// RAM read port plus FIFO push port of one loader stream.
// master = loader side, slave = RAM/FIFO side.
interface tile_ram_to_fifo_if #(
  parameter int AW = tile_ram_to_fifo_pkg::AW_DEF,
  parameter int DW = tile_ram_to_fifo_pkg::DW_DEF
);
  logic          ram_rd_ena;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] data_from_ram;
  logic          fifo_push;
  logic          fifo_almost_full;
  logic [DW-1:0] data_to_fifo;

  modport master (
    output ram_rd_ena, ram_addr, fifo_push, data_to_fifo,
    input  data_from_ram, fifo_almost_full
  );

  modport slave (
    input  ram_rd_ena, ram_addr, fifo_push, data_to_fifo,
    output data_from_ram, fifo_almost_full
  );
endinterface

// File: rtl/tile_ram_to_fifo_addr_gen.sv
// tile_addr_gen: walks channel/row/col positions of a tile (optionally with
// a P-wide zero border) and produces RAM addresses incrementally from the
// base and strides, without multipliers. Address only moves on interior
// positions; border positions are flagged through is_pad.
module tile_addr_gen
  import tile_ram_to_fifo_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [AW-1:0]    cfg_base,
  input  logic [AW-1:0]    cfg_row_stride,
  input  logic [AW-1:0]    cfg_ch_stride,
  input  logic [DIM_W-1:0] cfg_ch_num,
  input  logic [DIM_W-1:0] cfg_row_num,
  input  logic [DIM_W-1:0] cfg_col_num,
  input  logic [PAD_W-1:0] cfg_pad,
  output logic [AW-1:0]    addr,
  output logic             is_pad,
  output logic             last
);
  // One extra bit so that count + 2P cannot overflow.
  localparam int EW = DIM_W + 1;

  logic [EW-1:0]    pad_ext, pad_twice;
  logic [AW-1:0]    row_stride_reg, ch_stride_reg;
  logic [DIM_W-1:0] ch_num_reg;
  logic [EW-1:0]    pad_reg, row_ext_reg, col_ext_reg, row_hi_reg, col_hi_reg;
  logic [EW-1:0]    col_idx_reg, col_idx_next, row_idx_reg, row_idx_next;
  logic [DIM_W-1:0] ch_idx_reg, ch_idx_next;
  logic [AW-1:0]    addr_reg, addr_next, row_ptr_reg, row_ptr_next;
  logic [AW-1:0]    ch_ptr_reg, ch_ptr_next;
  logic             col_inner, row_inner, col_end, row_end, ch_end;
  logic             col_inner_last, row_inner_last;

  assign pad_ext   = {{(EW-PAD_W){1'b0}}, cfg_pad};
  assign pad_twice = {{(EW-PAD_W-1){1'b0}}, cfg_pad, 1'b0};

  assign col_inner      = (col_idx_reg >= pad_reg) && (col_idx_reg < col_hi_reg);
  assign row_inner      = (row_idx_reg >= pad_reg) && (row_idx_reg < row_hi_reg);
  assign col_end        = (col_idx_reg == col_ext_reg - EW'(1));
  assign row_end        = (row_idx_reg == row_ext_reg - EW'(1));
  assign ch_end         = (ch_idx_reg == ch_num_reg - DIM_W'(1));
  assign col_inner_last = (col_idx_reg == col_hi_reg - EW'(1));
  assign row_inner_last = (row_idx_reg == row_hi_reg - EW'(1));

  assign is_pad = !(col_inner && row_inner);
  assign last   = col_end && row_end && ch_end;
  assign addr   = addr_reg;

  // Next position and next address for one step of the walk.
  always_comb begin
    col_idx_next = col_idx_reg;
    row_idx_next = row_idx_reg;
    ch_idx_next  = ch_idx_reg;
    addr_next    = addr_reg;
    row_ptr_next = row_ptr_reg;
    ch_ptr_next  = ch_ptr_reg;
    if (step) begin
      if (col_end) begin
        col_idx_next = '0;
        if (row_end) begin
          row_idx_next = '0;
          ch_idx_next  = ch_idx_reg + DIM_W'(1);
        end else begin
          row_idx_next = row_idx_reg + EW'(1);
        end
      end else begin
        col_idx_next = col_idx_reg + EW'(1);
      end
      // Pointers move only when a real word is consumed; the last interior
      // word of a row/channel jumps to the next row/channel start.
      if (!is_pad) begin
        if (col_inner_last) begin
          if (row_inner_last) begin
            ch_ptr_next  = ch_ptr_reg + ch_stride_reg;
            row_ptr_next = ch_ptr_next;
            addr_next    = ch_ptr_next;
          end else begin
            row_ptr_next = row_ptr_reg + row_stride_reg;
            addr_next    = row_ptr_next;
          end
        end else begin
          addr_next = addr_reg + AW'(1);
        end
      end
    end
  end

  // Latch configuration on load, otherwise advance the walk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_stride_reg <= '0;
      ch_stride_reg  <= '0;
      ch_num_reg     <= '0;
      pad_reg        <= '0;
      row_ext_reg    <= '0;
      col_ext_reg    <= '0;
      row_hi_reg     <= '0;
      col_hi_reg     <= '0;
      col_idx_reg    <= '0;
      row_idx_reg    <= '0;
      ch_idx_reg     <= '0;
      addr_reg       <= '0;
      row_ptr_reg    <= '0;
      ch_ptr_reg     <= '0;
    end else if (load) begin
      row_stride_reg <= cfg_row_stride;
      ch_stride_reg  <= cfg_ch_stride;
      ch_num_reg     <= cfg_ch_num;
      pad_reg        <= pad_ext;
      row_ext_reg    <= EW'(cfg_row_num) + pad_twice;
      col_ext_reg    <= EW'(cfg_col_num) + pad_twice;
      row_hi_reg     <= EW'(cfg_row_num) + pad_ext;
      col_hi_reg     <= EW'(cfg_col_num) + pad_ext;
      col_idx_reg    <= '0;
      row_idx_reg    <= '0;
      ch_idx_reg     <= '0;
      addr_reg       <= cfg_base;
      row_ptr_reg    <= cfg_base;
      ch_ptr_reg     <= cfg_base;
    end else begin
      col_idx_reg    <= col_idx_next;
      row_idx_reg    <= row_idx_next;
      ch_idx_reg     <= ch_idx_next;
      addr_reg       <= addr_next;
      row_ptr_reg    <= row_ptr_next;
      ch_ptr_reg     <= ch_ptr_next;
    end
  end

endmodule

// File: rtl/tile_ram_to_fifo.sv
// tile_ram_to_fifo: fetches a channels x rows x cols tile from RAM and pushes
// it in order into a load FIFO. Reads are throttled by fifo_almost_full; an
// RD_LAT-deep valid/pad pipe turns each issued position into one push.
// Optional macro TILE_LOADER_PAD_EN adds cfg_pad (zero border of P words).
module tile_ram_to_fifo
  import tile_ram_to_fifo_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int DIM_W  = DIM_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW-1:0]     cfg_base,
  input  logic [DIM_W-1:0]  cfg_ch_num,
  input  logic [DIM_W-1:0]  cfg_row_num,
  input  logic [DIM_W-1:0]  cfg_col_num,
  input  logic [AW-1:0]     cfg_row_stride,
  input  logic [AW-1:0]     cfg_ch_stride,
`ifdef TILE_LOADER_PAD_EN
  input  logic [PAD_W-1:0]  cfg_pad,
`endif
  output logic              busy,
  output logic              done,
  tile_ram_to_fifo_if.master bus
);

  if (!lat_ok(RD_LAT)) begin : g_bad_lat
    $error("tile_ram_to_fifo: RD_LAT out of supported range");
  end

  state_t           state_reg, state_next;
  logic             accept, issue, zero_dim;
  logic             ag_is_pad, ag_last;
  logic [AW-1:0]    ag_addr;
  logic [PAD_W-1:0] pad_sel;
  logic [RD_LAT-1:0] vld_pipe_reg, vld_pipe_next;
  logic [RD_LAT-1:0] pad_pipe_reg, pad_pipe_next;

`ifdef TILE_LOADER_PAD_EN
  assign pad_sel = cfg_pad;
`else
  assign pad_sel = '0;
`endif

  assign accept   = (state_reg == ST_IDLE) && start;
  assign zero_dim = (cfg_ch_num == '0) || (cfg_row_num == '0) || (cfg_col_num == '0);
  // One walk position is consumed per unstalled ISSUE cycle, border or not.
  assign issue    = (state_reg == ST_ISSUE) && !bus.fifo_almost_full;

  tile_addr_gen #(
    .AW    (AW),
    .DIM_W (DIM_W)
  ) u_addr_gen (
    .clk            (clk),
    .rst            (rst),
    .load           (accept),
    .step           (issue),
    .cfg_base       (cfg_base),
    .cfg_row_stride (cfg_row_stride),
    .cfg_ch_stride  (cfg_ch_stride),
    .cfg_ch_num     (cfg_ch_num),
    .cfg_row_num    (cfg_row_num),
    .cfg_col_num    (cfg_col_num),
    .cfg_pad        (pad_sel),
    .addr           (ag_addr),
    .is_pad         (ag_is_pad),
    .last           (ag_last)
  );

  // Valid/pad pipe: stage 0 captures the issue, the top stage drives the push.
  assign vld_pipe_next[0] = issue;
  assign pad_pipe_next[0] = issue && ag_is_pad;
  for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_pipe
    assign vld_pipe_next[gi] = vld_pipe_reg[gi-1];
    assign pad_pipe_next[gi] = pad_pipe_reg[gi-1];
  end

  // Shift the return-path tracking pipe; reset discards in-flight reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_reg <= '0;
      pad_pipe_reg <= '0;
    end else begin
      vld_pipe_reg <= vld_pipe_next;
      pad_pipe_reg <= pad_pipe_next;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // FSM next state. An empty tile passes through DRAIN (pipe already empty),
  // which places its done pulse two cycles after start.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (start) state_next = zero_dim ? ST_DRAIN : ST_ISSUE;
      ST_ISSUE:  if (issue && ag_last) state_next = ST_DRAIN;
      ST_DRAIN:  if (vld_pipe_next == '0) state_next = ST_FINISH;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign busy             = (state_reg != ST_IDLE);
  assign done             = (state_reg == ST_FINISH);
  assign bus.ram_rd_ena   = issue && !ag_is_pad;
  assign bus.ram_addr     = ag_addr;
  assign bus.fifo_push    = vld_pipe_reg[RD_LAT-1];
  assign bus.data_to_fifo = (vld_pipe_reg[RD_LAT-1] && !pad_pipe_reg[RD_LAT-1])
                            ? bus.data_from_ram : '0;

endmodule
